// File: rtl/tx_burst_ctrl.sv
// Transmit burst shaper: frames modulator I/Q into bursts with linear ramps and a zero guard.
// Optional ramps are built only when TX_BURST_RAMP_EN is defined; otherwise bursts are pass-through.
module tx_burst_ctrl #(
  parameter int WIDTH            = 16,
  parameter int LEN_WIDTH        = 16,
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int RAMP_SHIFT       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEN_WIDTH-1:0]        TX_BURST_LEN,
  input  logic [MAX_WINDOW_WIDTH-1:0] TX_GUARD,
  input  logic                        burst_start,
  input  logic                        sample_en,
  input  logic signed [WIDTH-1:0]     I_tdata,
  input  logic signed [WIDTH-1:0]     Q_tdata,
  input  logic                        in_tvalid,
  output logic                        in_tready,
  output logic signed [WIDTH-1:0]     I_out,
  output logic signed [WIDTH-1:0]     Q_out,
  output logic                        out_tvalid,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_err,
  output logic                        underrun
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_ACTIVE    = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_GUARD     = 3'd4;

  localparam int PW = WIDTH + RAMP_SHIFT + 1;
  localparam logic [RAMP_SHIFT:0]  GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = 1;
  localparam logic [LEN_WIDTH-1:0] RAMP_N    = {{(LEN_WIDTH-RAMP_SHIFT-1){1'b0}}, GAIN_FULL};
`ifdef TX_BURST_RAMP_EN
  localparam logic [LEN_WIDTH-1:0] MIN_LEN   = RAMP_N << 1;
`else
  localparam logic [LEN_WIDTH-1:0] MIN_LEN   = LEN_ONE;
`endif

  logic [2:0]                  state_q, state_d;
  logic [LEN_WIDTH-1:0]        rem_q, rem_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [MAX_WINDOW_WIDTH-1:0] guard_q, guard_d;
  logic signed [WIDTH-1:0]     i_out_q, i_out_d, q_out_q, q_out_d;
  logic                        out_tvalid_q;
  logic                        tx_done_q, tx_done_d;
  logic                        tx_err_q, tx_err_d;
  logic                        underrun_q, underrun_d;

  logic                        data_st;
  logic                        burst_end;
  logic [RAMP_SHIFT:0]         gain;
  logic signed [PW-1:0]        gain_s, i_prod, q_prod;
  logic signed [WIDTH-1:0]     i_shaped, q_shaped;

  assign data_st   = (state_q == S_RAMP_UP) || (state_q == S_ACTIVE) || (state_q == S_RAMP_DOWN);
  assign in_tready = sample_en && data_st;

  // rem_q counts down within a state, so ramp gains derive directly from it
  always_comb begin
    case (state_q)
      S_RAMP_UP:   gain = GAIN_FULL - rem_q[RAMP_SHIFT:0];
      S_RAMP_DOWN: gain = rem_q[RAMP_SHIFT:0];
      default:     gain = GAIN_FULL;
    endcase
    gain_s   = $signed(PW'(gain));
    i_prod   = PW'(I_tdata) * gain_s;
    q_prod   = PW'(Q_tdata) * gain_s;
    i_shaped = WIDTH'(i_prod >>> RAMP_SHIFT);
    q_shaped = WIDTH'(q_prod >>> RAMP_SHIFT);
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    guard_d    = guard_q;
    i_out_d    = '0;
    q_out_d    = '0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    underrun_d = 1'b0;
    burst_end  = 1'b0;

    if (sample_en && data_st) begin
      if (in_tvalid) begin
        i_out_d = i_shaped;
        q_out_d = q_shaped;
      end else begin
        underrun_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (burst_start) begin
          if (TX_BURST_LEN >= MIN_LEN) begin
            len_d   = TX_BURST_LEN;
            guard_d = TX_GUARD;
`ifdef TX_BURST_RAMP_EN
            state_d = S_RAMP_UP;
            rem_d   = RAMP_N - LEN_ONE;
`else
            state_d = S_ACTIVE;
            rem_d   = TX_BURST_LEN - LEN_ONE;
`endif
          end else begin
            tx_err_d = 1'b1;
          end
        end
      end
      S_RAMP_UP: begin
        if (sample_en) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == '0) begin
            if (len_q == MIN_LEN) begin
              state_d = S_RAMP_DOWN;
              rem_d   = RAMP_N - LEN_ONE;
            end else begin
              state_d = S_ACTIVE;
              rem_d   = len_q - MIN_LEN - LEN_ONE;
            end
          end
        end
      end
      S_ACTIVE: begin
        if (sample_en) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == '0) begin
`ifdef TX_BURST_RAMP_EN
            state_d = S_RAMP_DOWN;
            rem_d   = RAMP_N - LEN_ONE;
`else
            burst_end = 1'b1;
`endif
          end
        end
      end
      S_RAMP_DOWN: begin
        if (sample_en) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == '0) burst_end = 1'b1;
        end
      end
      S_GUARD: begin
        if (sample_en) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == '0) begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // with no guard the burst's own last sample carries tx_done
    if (burst_end) begin
      if (guard_q != '0) begin
        state_d = S_GUARD;
        rem_d   = LEN_WIDTH'(guard_q) - LEN_ONE;
      end else begin
        state_d   = S_IDLE;
        tx_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      len_q        <= '0;
      guard_q      <= '0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      out_tvalid_q <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_err_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      len_q        <= len_d;
      guard_q      <= guard_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      out_tvalid_q <= sample_en;
      tx_done_q    <= tx_done_d;
      tx_err_q     <= tx_err_d;
      underrun_q   <= underrun_d;
    end
  end

  assign I_out      = i_out_q;
  assign Q_out      = q_out_q;
  assign out_tvalid = out_tvalid_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/tx_burst_ctrl.md
# tx_burst_ctrl

Transmit-side burst shaper: the counterpart of the receive signal detector. Takes modulator I/Q samples, frames them into bursts of programmable length with linear ramp-up/ramp-down envelopes, and enforces a zero-amplitude guard interval between bursts. This lets the far-end receiver's threshold/window detector see clean signal-present and signal-absent periods. Sits between the modulator output and the DAC interface, clocked at 16.384 MHz, with one output sample per `sample_en` strobe.

## Interface
- `WIDTH`, 16: I/Q sample width, signed two's complement.
- `LEN_WIDTH`, 16: burst length counter width.
- `MAX_WINDOW_WIDTH`, 8: guard length width.
- `RAMP_SHIFT`, 3: ramp length N = 2^RAMP_SHIFT samples.

- `clk` in 1: system clock, 16.384 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `TX_BURST_LEN` in LEN_WIDTH: samples per burst, including ramps. Latched at `burst_start`.
- `TX_GUARD` in MAX_WINDOW_WIDTH: zero samples after each burst. Latched at `burst_start`.
- `burst_start` in 1: single-cycle burst request.
- `sample_en` in 1: output sample strobe, at most one per cycle.
- `I_tdata`, `Q_tdata` in WIDTH: modulator samples.
- `in_tvalid` in 1: modulator sample valid.
- `in_tready` out 1: combinational; equals `sample_en` AND state in {RAMP_UP, ACTIVE, RAMP_DOWN}.
- `I_out`, `Q_out` out WIDTH: shaped samples, registered.
- `out_tvalid` out 1: registered copy of `sample_en`.
- `tx_busy` out 1: state != IDLE.
- `tx_done` out 1: single-cycle pulse at end of guard.
- `tx_err` out 1: single-cycle pulse when a burst is rejected.
- `underrun` out 1: single-cycle pulse when a sample is missing.

## Operation
- FSM states: IDLE, RAMP_UP, ACTIVE, RAMP_DOWN, GUARD. Sample counter k counts `sample_en` strobes within a state.
- **IDLE:** on `burst_start`, if `TX_BURST_LEN` >= 2N, latch the length and guard and go to RAMP_UP. Otherwise pulse `tx_err` and stay in IDLE.
- **Busy:** `burst_start` outside IDLE is ignored, with no error.
- **RAMP_UP:** N samples with gain g = k+1, so gains are 1..N. Then go to ACTIVE.
- **ACTIVE:** `TX_BURST_LEN` − 2N samples with g = N. A zero count goes straight to RAMP_DOWN.
- **RAMP_DOWN:** N samples with g = N−1−k, so gains are N−1..0.
- **After RAMP_DOWN:** go to GUARD if `TX_GUARD` > 0, else to IDLE.
- **GUARD:** `TX_GUARD` samples of zero, then IDLE.
- **Input consumption:** in data states a sample is taken when `sample_en` && `in_tvalid`.
- **Underrun:** `sample_en` with `in_tvalid`=0 in a data state outputs zero, pulses `underrun`, and still counts the sample. Burst timing never stretches.
- **Arithmetic:** out = (in × g) >>> RAMP_SHIFT, with a WIDTH+RAMP_SHIFT+1 signed product. Rounding is floor (arithmetic shift). Gain g=N is exact, and no saturation is needed.
- **Outside bursts:** in IDLE and GUARD, the output is zero whenever `out_tvalid` is high, giving a continuous DAC stream.
- **`tx_done`:** asserted with the `out_tvalid` of the final guard sample. If `TX_GUARD`=0, it is asserted with the final burst sample.

## Timing
- **Reset:** on `rst`, state goes to IDLE. `I_out`, `Q_out`, `out_tvalid`, `tx_done`, `tx_err` and `underrun` all clear to 0 on the next edge.
- **Reset mid-burst:** aborts immediately, with no `tx_done`.
- **Output latency:** `sample_en` at cycle t gives `out_tvalid`/`I_out`/`Q_out` at t+1.
- **`burst_start` at t (IDLE):** state is RAMP_UP from t+1. A `sample_en` at t is treated as IDLE and outputs zero.
- **Back-to-back bursts:** `burst_start` is accepted in the cycle after `tx_done`.
- **Pulse alignment:** `underrun` and `tx_err` are registered and align with the corresponding `out_tvalid` and the t+1 cycle respectively.

## Configuration
- **`TX_BURST_RAMP_EN` defined:** ramps as above; minimum burst length is 2N.
- **Not defined:** RAMP_UP and RAMP_DOWN are never entered. IDLE goes to ACTIVE, which runs `TX_BURST_LEN` samples at g=N (pass-through). The minimum length is 1, and a length of 0 pulses `tx_err`.

## Test plan
All tests use RAMP_SHIFT=2 (N=4) with the macro on unless noted.
- **Nominal burst:** len=10, guard=3, I=1000, Q=−1000 constant, `sample_en` every 4 clocks. Required I_out: 250, 500, 750, 1000, 1000, 1000, 750, 500, 250, 0, then 0, 0, 0. Q_out is the negation. `tx_done` is asserted with the 13th output.
- **Short burst rejected:** len=7. Required: `tx_err` pulse at t+1, `tx_busy` stays 0, all outputs zero.
- **Underrun:** len=8, `in_tvalid` dropped at sample index 5. Required: that output is 0, `underrun` pulses once, and the burst still ends after 8 samples.
- **Ignored start and reset mid-burst:** `burst_start` at sample 3 of a len=10 burst has no effect; `rst` at sample 6 gives IDLE and zero outputs next edge, with no `tx_done`.
- **Zero guard:** guard=0 with back-to-back bursts. Required: `tx_done` with the final burst sample, and the second burst's first output (gain 1) follows with no zero gap beyond one IDLE strobe.
- **Macro undefined:** len=3, I=1000. Required: 1000, 1000, 1000. len=0 pulses `tx_err`.
